// File: rtl/fir_mac_seq_pkg.sv
// Shared types and helpers for the fir_mac_seq filter: FSM states, DSP operand widths
// and the output saturation function.
package fir_mac_seq_pkg;

   localparam int unsigned DspAWidth = 25;
   localparam int unsigned DspBWidth = 18;
   localparam int unsigned DspPWidth = 48;

   typedef enum logic [1:0] {
      StIdle,
      StMac,
      StOut
   } state_e;

   // Clamp a signed accumulator value to the signed range of a w-bit result (w < 48).
   function automatic logic signed [DspPWidth-1:0] sat_to_width(
      input logic signed [DspPWidth-1:0] v,
      input int unsigned                 w
   );
      logic signed [DspPWidth-1:0] hi;
      logic signed [DspPWidth-1:0] lo;
      hi = $signed(DspPWidth'(1) << (w - 1)) - DspPWidth'(1);
      lo = -hi - DspPWidth'(1);
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/fir_mac_seq_mult_add.sv
// Combinational multiply-add in the shape of the DSP48E1 datapath: p = a*b + c, with
// all operands sign-extended to the P width before the arithmetic.
module fir_mac_seq_mult_add #(
   parameter int unsigned A = 25,
   parameter int unsigned B = 18,
   parameter int unsigned C = 48,
   parameter int unsigned P = 48
) (
   input  logic [A-1:0] a,
   input  logic [B-1:0] b,
   input  logic [C-1:0] c,
   output logic [P-1:0] p
);

   logic signed [P-1:0] a_ext;
   logic signed [P-1:0] b_ext;
   logic signed [P-1:0] c_ext;
   logic signed [P-1:0] sum;

   assign a_ext = P'($signed(a));
   assign b_ext = P'($signed(b));
   assign c_ext = P'($signed(c));
   assign sum   = (a_ext * b_ext) + c_ext;
   assign p     = sum;

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one sample per handshake, NTAPS multiply-accumulate cycles through a
// single mult_add, then a scaled and saturated result on a valid/ready output.
module fir_mac_seq
   import fir_mac_seq_pkg::*;
#(
   parameter int unsigned NTAPS       = 8,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned COEFF_WIDTH = 25,
   parameter int unsigned OUT_WIDTH   = 16,
   parameter int unsigned OUT_SHIFT   = 0,
   localparam int unsigned KW         = $clog2(NTAPS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   coef_we,
   input  logic [KW-1:0]          coef_addr,
   input  logic [COEFF_WIDTH-1:0] coef_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_WIDTH-1:0]   out_data
);

   state_e                  state_q, state_d;
   logic [KW-1:0]           k_q, k_d;
   logic [DspPWidth-1:0]    acc_q, acc_d;
   logic                    out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
   logic [DATA_WIDTH-1:0]   x_q [NTAPS];
   logic [COEFF_WIDTH-1:0]  h_q [NTAPS];

   logic                    accept;
   logic                    shift_en;
   logic                    coef_wr_en;
   logic [DspPWidth-1:0]    p;
   logic signed [DspPWidth-1:0] p_scaled;
   logic signed [DspPWidth-1:0] p_sat;

   assign in_ready   = (state_q == StIdle) & ~rst;
   assign accept     = in_valid & in_ready;
   assign coef_wr_en = coef_we & (state_q == StIdle) & (int'(coef_addr) < NTAPS);

   fir_mac_seq_mult_add #(
      .A (COEFF_WIDTH),
      .B (DATA_WIDTH),
      .C (DspPWidth),
      .P (DspPWidth)
   ) u_mult_add (
      .a (h_q[k_q]),
      .b (x_q[k_q]),
      .c (acc_q),
      .p (p)
   );

   // The last MAC product is scaled straight from p so the result lands with out_valid.
   assign p_scaled = $signed(p) >>> OUT_SHIFT;
   assign p_sat    = sat_to_width(p_scaled, OUT_WIDTH);

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      shift_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               shift_en = 1'b1;
               acc_d    = '0;
               k_d      = '0;
               state_d  = StMac;
            end
         end
         StMac: begin
            acc_d = p;
            if (k_q == KW'(NTAPS - 1)) begin
               state_d     = StOut;
               out_valid_d = 1'b1;
               out_data_d  = p_sat[OUT_WIDTH-1:0];
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         StOut: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         k_q         <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            x_q[i] <= '0;
            h_q[i] <= '0;
         end
      end else begin
         if (shift_en) begin
            for (int i = 1; i < NTAPS; i++) begin
               x_q[i] <= x_q[i-1];
            end
            x_q[0] <= in_data;
         end
         if (coef_wr_en) begin
            h_q[coef_addr] <= coef_data;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Randomised and directed bench for fir_mac_seq with an array-based FIR reference model.
module tb_fir_mac_seq;

   localparam int unsigned NTAPS = 4;
   localparam int unsigned DW    = 16;
   localparam int unsigned CW    = 25;
   localparam int unsigned OW    = 16;
   localparam int unsigned KW    = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] in_data = '0;
   logic                 coef_we = 1'b0;
   logic [KW-1:0]        coef_addr = '0;
   logic [CW-1:0]        coef_data = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic signed [OW-1:0] out_data;

   int n_total = 0;
   int n_bad   = 0;

   longint hm [NTAPS];
   longint xm [NTAPS];

   always #5 clk = ~clk;

   fir_mac_seq #(
      .NTAPS       (NTAPS),
      .DATA_WIDTH  (DW),
      .COEFF_WIDTH (CW),
      .OUT_WIDTH   (OW),
      .OUT_SHIFT   (0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NTAPS; i++) begin
         hm[i] = 0;
         xm[i] = 0;
      end
   endfunction

   function automatic void model_accept(input longint s);
      for (int i = NTAPS - 1; i > 0; i--) xm[i] = xm[i-1];
      xm[0] = s;
   endfunction

   // Dot product of taps and delay line, wrapped to 48 bits, then clamped to OW bits.
   function automatic longint model_out();
      longint acc;
      longint hi;
      acc = 0;
      for (int i = 0; i < NTAPS; i++) acc += hm[i] * xm[i];
      acc = (acc <<< 16) >>> 16;
      hi  = (longint'(1) <<< (OW - 1)) - 1;
      if (acc > hi) acc = hi;
      if (acc < -hi - 1) acc = -hi - 1;
      return acc;
   endfunction

   task automatic wr_coef(input int a, input longint v);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = KW'(a);
      coef_data = CW'(v);
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      hm[a]   = v;
   endtask

   task automatic push(input longint s, input int hold, input bit bad_wr);
      int                   n;
      longint               exp;
      logic signed [OW-1:0] held;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", longint'(in_ready), 1);
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      in_data   = DW'(s);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_accept(s);
      exp = model_out();
      if (bad_wr) begin
         coef_we   = 1'b1;
         coef_addr = KW'(1);
         coef_data = CW'(50);
      end
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!out_valid && n < 30);
      check("latency", longint'(n), longint'(NTAPS));
      check("out_data", longint'(out_data), exp);
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", longint'(out_valid), 1);
         check("hold_data", longint'(out_data), longint'(held));
         check("hold_ready", longint'(in_ready), 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      check("release_valid", longint'(out_valid), 0);
      check("release_ready", longint'(in_ready), 1);
   endtask

   initial begin
      int                   n;
      logic signed [CW-1:0] rc;
      logic signed [DW-1:0] rs;
      model_reset();

      // Reset held for five cycles.
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_data", longint'(out_data), 0);
      check("rst_in_ready", longint'(in_ready), 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", longint'(in_ready), 1);
      check("post_rst_valid", longint'(out_valid), 0);

      // Impulse through h = {1,2,3,4}.
      for (int i = 0; i < NTAPS; i++) wr_coef(i, longint'(i + 1));
      push(1, 0, 1'b0);
      for (int i = 1; i < NTAPS; i++) push(0, 0, 1'b0);

      // Backpressure with all-ones taps.
      for (int i = 0; i < NTAPS; i++) wr_coef(i, 1);
      push(100, 10, 1'b0);

      // Saturation at both rails.
      for (int i = 0; i < NTAPS; i++) wr_coef(i, 16777215);
      for (int i = 0; i < NTAPS; i++) push(32767, 0, 1'b0);
      for (int i = 0; i < NTAPS; i++) push(-32768, 0, 1'b0);

      // Writes while busy must not land; the impulse still sees the loaded taps.
      for (int i = 0; i < NTAPS; i++) wr_coef(i, longint'(i + 1));
      push(1, 2, 1'b1);
      for (int i = 1; i < NTAPS; i++) push(0, 0, 1'b1);
      push(1, 0, 1'b0);
      for (int i = 1; i < NTAPS; i++) push(0, 0, 1'b0);

      // Reset pulse during MAC: no result, state and storage cleared.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'sd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready", longint'(in_ready), 0);
      check("midrst_valid", longint'(out_valid), 0);
      rst = 1'b0;
      model_reset();
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      check("midrst_no_pulse", longint'(n), 0);
      push(7, 0, 1'b0);
      for (int i = 0; i < NTAPS; i++) wr_coef(i, longint'(i + 1));
      push(1, 0, 1'b0);
      push(0, 0, 1'b0);

      // Random samples, coefficients, backpressure and stray writes.
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) rc = CW'($urandom);
            else rc = CW'($signed($urandom_range(0, 255)) - 128);
            wr_coef(int'($urandom_range(0, NTAPS - 1)), longint'(rc));
         end
         rs = DW'($urandom);
         push(longint'(rs), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
